systolic_feed_ctrl: RTL

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_feed_ctrl.sv
// Operand feeder for a 2x2 systolic array: four lane buffers are loaded while idle, then streamed
// with per-lane start offsets, followed by a zero-flush drain and a capture of the array results.
module systolic_feed_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [7:0]  wr_data,
    input  logic [15:0] offset,
    input  logic [3:0]  drain,
    input  logic        start,
    input  logic [7:0]  out1,
    input  logic [7:0]  out2,
    output logic [7:0]  up1,
    output logic [7:0]  up2,
    output logic [7:0]  left1,
    output logic [7:0]  left2,
    output logic [7:0]  res1,
    output logic [7:0]  res2,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [4:0]              t_q, t_d;
    logic [4:0]              tlen_q, tlen_d;
    logic [3:0]              dcnt_q, dcnt_d;
    logic [3:0]              drain_q, drain_d;
    logic [3:0][3:0]         off_q, off_d;
    logic [3:0][CW-1:0]      cnt_q, cnt_d;
    logic [3:0][7:0]         stream_q, stream_d;
    logic [7:0]              res1_q, res1_d;
    logic [7:0]              res2_q, res2_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [3:0]              wr_hit;
    logic                    is_idle;
    logic                    wr_drop;
    logic                    drain_last;
    logic                    any_cnt;
    logic [4:0]              tmax;
    logic [4:0]              lane_sum;

    assign is_idle    = (state_q == S_IDLE);
    assign wr_drop    = wr_en && is_idle && (cnt_q[wr_sel] == FULL);
    // A drain length of 0 behaves as 1: the first drain cycle is then also the last.
    assign drain_last = (state_q == S_DRAIN) && (({1'b0, dcnt_q} + 5'd1) >= {1'b0, drain_q});
    assign any_cnt    = |cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drain_last) begin
            cnt_d = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_hit[i]) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Run length uses post-write counts so a write on the start edge is part of the job.
    always_comb begin
        tmax     = '0;
        lane_sum = '0;
        for (int i = 0; i < 4; i++) begin
            lane_sum = {1'b0, offset[i*4 +: 4]} + 5'(cnt_d[i]);
            if (lane_sum > tmax) begin
                tmax = lane_sum;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        tlen_d  = tlen_q;
        dcnt_d  = dcnt_q;
        drain_d = drain_q;
        off_d   = off_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        done_d  = 1'b0;
        err_d   = wr_drop;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!any_cnt) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        t_d     = '0;
                        tlen_d  = tmax;
                        off_d   = offset;
                        drain_d = drain;
                    end
                end
            end
            S_RUN: begin
                if (t_q == tlen_q - 5'd1) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    t_d = t_q + 5'd1;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_d = S_IDLE;
                    t_d     = '0;
                    res1_d  = out1;
                    res2_d  = out2;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Each lane owns a small buffer; the stream register holds the value for the upcoming cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0]    buf_mem [DEPTH];
            logic [5:0]    rel;
            logic          in_win;
            logic [AW-1:0] rd_idx;
            logic [7:0]    rd_data;
            logic [7:0]    lane_val;

            assign wr_hit[gi] = wr_en && is_idle && (wr_sel == 2'(gi)) && (cnt_q[gi] != FULL);

            always_ff @(posedge clk) begin
                if (wr_hit[gi]) begin
                    buf_mem[cnt_q[gi][AW-1:0]] <= wr_data;
                end
            end

            always_comb begin
                rel     = {1'b0, t_d} - {2'b00, off_d[gi]};
                in_win  = ({1'b0, t_d} >= {2'b00, off_d[gi]}) && (rel < 6'(cnt_d[gi]));
                rd_idx  = rel[AW-1:0];
                rd_data = buf_mem[rd_idx];
                // Forward a byte written on the start edge, it is not in the array yet.
                if (wr_hit[gi] && (rd_idx == cnt_q[gi][AW-1:0])) begin
                    rd_data = wr_data;
                end
                lane_val = ((state_d == S_RUN) && in_win) ? rd_data : 8'd0;
            end

            assign stream_d[gi] = lane_val;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            tlen_q   <= '0;
            dcnt_q   <= '0;
            drain_q  <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            stream_q <= '0;
            res1_q   <= '0;
            res2_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            tlen_q   <= tlen_d;
            dcnt_q   <= dcnt_d;
            drain_q  <= drain_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            stream_q <= stream_d;
            res1_q   <= res1_d;
            res2_q   <= res2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign up1   = stream_q[0];
    assign up2   = stream_q[1];
    assign left1 = stream_q[2];
    assign left2 = stream_q[3];
    assign res1  = res1_q;
    assign res2  = res2_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
